instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Owns the program counter and instruction register for the multicycle RV32I core.
- Sits directly upstream of the control FSM: fetches the word at PC from instruction memory over a req/ready + rvalid handshake, latches it, and presents opcode/instr back to control.
- Control drives fetch_start during its FETCH state and pc_update for jumps/branches.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value on reset
TIMEOUT_CYCLES, 255, max cycles in ADDR+DATA before fault (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
fetch_start  in  1  one-cycle request to fetch at current pc
pc_update  in  1  load pc from pc_next
pc_next  in  XLEN  jump/branch target
imem_req  out  1  memory address phase valid
imem_addr  out  XLEN  fetch address
imem_ready  in  1  memory accepts address
imem_rvalid  in  1  read data valid
imem_rdata  in  XLEN  read data
instr  out  XLEN  latched instruction
opcode  out  7  instr[6:0], to control FSM
pc  out  XLEN  current PC
old_pc  out  XLEN  PC of latched instruction
fetch_busy  out  1  high in ADDR/DATA
fetch_done  out  1  one-cycle pulse, instr valid
fault  out  1  sticky fault flag
fault_cause  out  2  00 none, 01 misaligned, 10 timeout

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; pc=RESET_PC; old_pc=RESET_PC.
  - instr=32'h0000_0013 (NOP); imem_req=0; fetch_done=0; fault=0; fault_cause=00; timer=0.
- States: IDLE, ADDR, DATA, FAULT.
- IDLE:
  - fetch_start=1 and pc_update=0:
    - pc[1:0]!=00: go to FAULT; fault_cause=01; no request issued.
    - otherwise: go to ADDR.
  - pc_update=1: pc<=pc_next next edge; fetch_start in the same cycle is ignored (pc_update has priority).
- ADDR:
  - imem_req=1 and imem_addr=pc, held stable until imem_ready=1.
  - On ready: go to DATA. If imem_rvalid=1 in the same cycle, capture immediately as below and return to IDLE (zero-latency memory).
- DATA:
  - imem_req=0; wait for imem_rvalid.
  - On rvalid: instr<=imem_rdata; old_pc<=pc; pc<=pc+4 (mod 2^XLEN, wraps 32'hFFFF_FFFC -> 0); fetch_done=1 for exactly the next cycle; go to IDLE.
- Timer:
  - Cleared on entry to ADDR; increments each cycle in ADDR/DATA.
  - Reaching TIMEOUT_CYCLES without capture: go to FAULT; fault_cause=10; imem_req drops.
- FAULT:
  - Sticky; fault=1; all inputs ignored; exit only via reset.
- While busy (ADDR/DATA): fetch_start and pc_update are ignored; pc does not change.
- A stray imem_rvalid in IDLE/ADDR-without-ready is ignored.
- Latency: minimum 2 cycles from fetch_start to fetch_done (IDLE->ADDR, then capture); fetch_done is registered.
- opcode is combinational from the instr register; outputs change only on clock edges or reset.
- Reset mid-transaction aborts immediately: imem_req=0; late rvalid after reset release is ignored (state IDLE).

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL)
  - fetch state typedef
  - NOP_INSTR
  - fault_cause encodings
- One natural sub-module: fetch_timeout_timer (clear, enable, expired output); the rest stays flat.

Test Plan:
- Reset, then fetch_start with ready=1 same cycle and rvalid=1 one cycle later, rdata=32'h0000_0033 -> imem_addr=0, fetch_done pulse, opcode=7'b0110011, pc=4, old_pc=0.
- pc_update with pc_next=32'h100, then fetch_start; ready held low 3 cycles -> imem_req and imem_addr=32'h100 stable 4 cycles; after capture pc=32'h104.
- Set pc to 32'hFFFF_FFFC and fetch -> pc wraps to 0; old_pc=32'hFFFF_FFFC.
- pc_update with pc_next=32'h102, then fetch_start -> no imem_req; fault=1, fault_cause=01; further fetch_start ignored.
- TIMEOUT_CYCLES=8, ready=1 but rvalid never asserted -> fault_cause=10 after 8 busy cycles; imem_req=0.
- Assert reset low while in DATA, release, then deliver rvalid -> instr stays NOP; pc=RESET_PC; no fetch_done.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I core: opcodes, fetch FSM states,
// fault encodings and small address helpers.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'b00,
        FETCH_ADDR  = 2'b01,
        FETCH_DATA  = 2'b10,
        FETCH_FAULT = 2'b11
    } fetch_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_TIMEOUT  = 2'b10
    } fault_cause_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_timeout_timer.sv
// Counts busy fetch cycles; expired flags the last allowed cycle so the FSM
// can fault on the edge that would exceed TIMEOUT_CYCLES.
module fetch_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_r;

    // busy-cycle counter, held at zero while the fetch unit is idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LAST_COUNT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC/IR, fetches over a req/ready + rvalid
// handshake, and raises a sticky fault on misaligned PC or memory timeout.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = {XLEN{1'b0}},
    parameter int              TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_start,
    input  logic            pc_update,
    input  logic [XLEN-1:0] pc_next,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] old_pc,
    output logic            fetch_busy,
    output logic            fetch_done,
    output logic            fault,
    output logic [1:0]      fault_cause
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    fetch_state_t    state_r, state_nxt_s;
    fault_cause_t    cause_r, cause_nxt_s;
    logic [XLEN-1:0] pc_r, pc_nxt_s;
    logic [XLEN-1:0] old_pc_r;
    logic [XLEN-1:0] instr_r;
    logic            fetch_done_r;
    logic            imem_req_r;
    logic            fetch_busy_r;
    logic            fault_r;
    logic            capture_s;
    logic            expired_s;
    logic            timer_clear_s;
    logic            timer_en_s;

    assign timer_clear_s = (state_r == FETCH_IDLE);
    assign timer_en_s    = (state_r == FETCH_ADDR) || (state_r == FETCH_DATA);

    fetch_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (expired_s)
    );

    // next-state, next-pc and capture decode; a capture wins over a timeout
    always_comb begin
        state_nxt_s = state_r;
        cause_nxt_s = cause_r;
        pc_nxt_s    = pc_r;
        capture_s   = 1'b0;
        case (state_r)
            FETCH_IDLE: begin
                if (pc_update) begin
                    pc_nxt_s = pc_next;
                end else if (fetch_start) begin
                    if (!is_word_aligned(pc_r[1:0])) begin
                        state_nxt_s = FETCH_FAULT;
                        cause_nxt_s = CAUSE_MISALIGN;
                    end else begin
                        state_nxt_s = FETCH_ADDR;
                    end
                end else begin
                    state_nxt_s = FETCH_IDLE;
                end
            end
            FETCH_ADDR: begin
                if (imem_ready && imem_rvalid) begin
                    capture_s   = 1'b1;
                    pc_nxt_s    = pc_r + PC_STEP;
                    state_nxt_s = FETCH_IDLE;
                end else if (expired_s) begin
                    state_nxt_s = FETCH_FAULT;
                    cause_nxt_s = CAUSE_TIMEOUT;
                end else if (imem_ready) begin
                    state_nxt_s = FETCH_DATA;
                end else begin
                    state_nxt_s = FETCH_ADDR;
                end
            end
            FETCH_DATA: begin
                if (imem_rvalid) begin
                    capture_s   = 1'b1;
                    pc_nxt_s    = pc_r + PC_STEP;
                    state_nxt_s = FETCH_IDLE;
                end else if (expired_s) begin
                    state_nxt_s = FETCH_FAULT;
                    cause_nxt_s = CAUSE_TIMEOUT;
                end else begin
                    state_nxt_s = FETCH_DATA;
                end
            end
            FETCH_FAULT: begin
                state_nxt_s = FETCH_FAULT;
            end
            default: begin
                state_nxt_s = FETCH_FAULT;
            end
        endcase
    end

    // state register and status outputs registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= FETCH_IDLE;
            cause_r      <= CAUSE_NONE;
            imem_req_r   <= 1'b0;
            fetch_busy_r <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cause_r      <= cause_nxt_s;
            imem_req_r   <= (state_nxt_s == FETCH_ADDR);
            fetch_busy_r <= (state_nxt_s == FETCH_ADDR) || (state_nxt_s == FETCH_DATA);
            fault_r      <= (state_nxt_s == FETCH_FAULT);
        end
    end

    // program counter, instruction register and completion pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r         <= RESET_PC;
            old_pc_r     <= RESET_PC;
            instr_r      <= XLEN'(NOP_INSTR);
            fetch_done_r <= 1'b0;
        end else begin
            pc_r         <= pc_nxt_s;
            fetch_done_r <= capture_s;
            if (capture_s) begin
                instr_r  <= imem_rdata;
                old_pc_r <= pc_r;
            end else begin
                instr_r  <= instr_r;
                old_pc_r <= old_pc_r;
            end
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign opcode      = instr_r[6:0];
    assign pc          = pc_r;
    assign old_pc      = old_pc_r;
    assign fetch_busy  = fetch_busy_r;
    assign fetch_done  = fetch_done_r;
    assign fault       = fault_r;
    assign fault_cause = cause_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected captures.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_update;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic [31:0] old_pc;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fault;
    logic [1:0]  fault_cause;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] old_pc;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    instr_fetch_unit #(
        .XLEN           (32),
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_update   (pc_update),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .pc          (pc),
        .old_pc      (old_pc),
        .fetch_busy  (fetch_busy),
        .fetch_done  (fetch_done),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_start = 1'b0;
        pc_update   = 1'b0;
        pc_next     = 32'h0000_0000;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // every fetch_done must match the oldest pending capture
    always @(negedge clk) begin
        if (reset === 1'b1 && fetch_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", {31'd0, fetch_done}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_instr", instr, e.instr);
                check("sb_old_pc", old_pc, e.old_pc);
                check("sb_pc", pc, e.pc);
                check("sb_opcode", {25'd0, opcode}, {25'd0, e.instr[6:0]});
            end
        end
    end

    initial begin
        apply_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_old_pc", old_pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_done", {31'd0, fetch_done}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_cause", {30'd0, fault_cause}, 32'd0);
        check("rst_busy", {31'd0, fetch_busy}, 32'd0);

        // zero-latency memory: ready and rvalid in the first ADDR cycle
        fetch_start = 1'b1;
        imem_ready  = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("t1_req", {31'd0, imem_req}, 32'd1);
        check("t1_addr", imem_addr, 32'h0);
        check("t1_busy", {31'd0, fetch_busy}, 32'd1);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0033;
        sb_q.push_back('{instr: 32'h0000_0033, old_pc: 32'h0, pc: 32'h4});
        tick();
        idle_inputs();
        check("t1_done", {31'd0, fetch_done}, 32'd1);
        check("t1_opcode", {25'd0, opcode}, {25'd0, 7'b0110011});
        tick();
        check("t1_done_pulse", {31'd0, fetch_done}, 32'd0);

        // pc_update beats fetch_start, then ready held low for 3 cycles
        pc_update   = 1'b1;
        pc_next     = 32'h0000_0100;
        fetch_start = 1'b1;
        tick();
        idle_inputs();
        check("t2_pc_load", pc, 32'h100);
        check("t2_not_busy", {31'd0, fetch_busy}, 32'd0);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_req_hold", {31'd0, imem_req}, 32'd1);
            check("t2_addr_hold", imem_addr, 32'h100);
            pc_update  = 1'b1;
            pc_next    = 32'hDEAD_BEE0;
            imem_ready = (i == 3) ? 1'b1 : 1'b0;
            tick();
        end
        idle_inputs();
        check("t2_data_req", {31'd0, imem_req}, 32'd0);
        check("t2_data_busy", {31'd0, fetch_busy}, 32'd1);
        check("t2_pc_frozen", pc, 32'h100);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        sb_q.push_back('{instr: 32'h0050_0093, old_pc: 32'h100, pc: 32'h104});
        tick();
        idle_inputs();
        check("t2_pc_inc", pc, 32'h104);
        tick();

        // PC wrap at the top of the address space
        pc_update = 1'b1;
        pc_next   = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_006F;
        sb_q.push_back('{instr: 32'h0000_006F, old_pc: 32'hFFFF_FFFC, pc: 32'h0});
        tick();
        idle_inputs();
        check("t3_pc_wrap", pc, 32'h0);
        check("t3_old_pc", old_pc, 32'hFFFF_FFFC);
        tick();

        // stray rvalid while idle is ignored
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        tick();
        idle_inputs();
        check("stray_instr", instr, 32'h0000_006F);
        check("stray_pc", pc, 32'h0);

        // misaligned PC faults without a request and stays faulted
        pc_update = 1'b1;
        pc_next   = 32'h0000_0102;
        tick();
        idle_inputs();
        fetch_start = 1'b1;
        tick();
        check("t4_req", {31'd0, imem_req}, 32'd0);
        check("t4_fault", {31'd0, fault}, 32'd1);
        check("t4_cause", {30'd0, fault_cause}, 32'd1);
        pc_update = 1'b1;
        pc_next   = 32'h0000_0000;
        tick();
        tick();
        idle_inputs();
        check("t4_sticky", {31'd0, fault}, 32'd1);
        check("t4_pc_kept", pc, 32'h102);
        check("t4_busy", {31'd0, fetch_busy}, 32'd0);

        // timeout: ready accepted but rvalid never arrives
        apply_reset();
        fetch_start = 1'b1;
        imem_ready  = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t5_busy", {31'd0, fetch_busy}, 32'd1);
            check("t5_no_fault", {31'd0, fault}, 32'd0);
            tick();
        end
        idle_inputs();
        check("t5_fault", {31'd0, fault}, 32'd1);
        check("t5_cause", {30'd0, fault_cause}, 32'd2);
        check("t5_req", {31'd0, imem_req}, 32'd0);

        // reset in DATA aborts; late rvalid afterwards is ignored
        apply_reset();
        fetch_start = 1'b1;
        imem_ready  = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        check("t6_in_data", {31'd0, fetch_busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("t6_req_abort", {31'd0, imem_req}, 32'd0);
        tick();
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0033;
        tick();
        idle_inputs();
        check("t6_instr_nop", instr, 32'h0000_0013);
        check("t6_pc", pc, 32'h0);
        check("t6_no_done", {31'd0, fetch_done}, 32'd0);
        tick();
        check("t6_no_done2", {31'd0, fetch_done}, 32'd0);

        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
